// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
//   in_valid/in_data/in_ready : source byte stream (transfer on valid && ready)
//   we/waddr/wdata            : single-cycle word write into instruction memory
// Modports:
//   master : environment side (byte source and memory write port)
//   slave  : loader side (consumes bytes, drives writes)
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer. Receives a length-prefixed byte frame
// (LEN[7:0], LEN[15:8], LEN*4 little-endian payload bytes), assembles 32-bit
// words and writes each through a one-cycle strobe while holding the core in
// reset.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- appends one checksum byte
// to the frame; the frame is good when (payload byte sum + checksum) mod 256 == 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse starting a load (ignored while busy)
//   bus        : byte stream in + instruction memory write port (slave modport)
//   busy       : load in progress
//   core_hold  : core reset request, same as busy
//   done, err  : level status of the last load
module imem_loader #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          core_hold,
    output logic          done,
    output logic          err
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned BUF_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CSUM;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t            state, state_n;
    logic [7:0]        len_lo, len_lo_n;
    logic [CNT_W-1:0]  len, len_n;
    logic [CNT_W-1:0]  wcnt, wcnt_n;
    logic [1:0]        bidx, bidx_n;
    logic [BUF_W-1:0]  shbuf, shbuf_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] waddr_q, waddr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic              in_ready_q, in_ready_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic              xfer;
    logic [CNT_W-1:0]  len_rx;
    logic [CNT_W-1:0]  wcnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum, sum_n;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_lo     <= '0;
            len        <= '0;
            wcnt       <= '0;
            bidx       <= '0;
            shbuf      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state      <= state_n;
            len_lo     <= len_lo_n;
            len        <= len_n;
            wcnt       <= wcnt_n;
            bidx       <= bidx_n;
            shbuf      <= shbuf_n;
            we_q       <= we_n;
            waddr_q    <= waddr_n;
            wdata_q    <= wdata_n;
            in_ready_q <= in_ready_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            err_q      <= err_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= sum_n;
`endif
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_n  = state;
        len_lo_n = len_lo;
        len_n    = len;
        wcnt_n   = wcnt;
        bidx_n   = bidx;
        shbuf_n  = shbuf;
        we_n     = 1'b0;
        waddr_n  = waddr_q;
        wdata_n  = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_n    = sum;
`endif
        xfer     = bus.in_valid && in_ready_q;
        len_rx   = {bus.in_data, len_lo};
        wcnt_inc = CNT_W'(wcnt + 1'b1);

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n = S_LEN0;
                    wcnt_n  = '0;
                    bidx_n  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_n   = '0;
`endif
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_lo_n = bus.in_data;
                    state_n  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_n = len_rx;
                    if (len_rx > CNT_W'(DEPTH)) begin
                        state_n = S_ERR;
                    end else if (len_rx == '0) begin
                        state_n = S_END;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // Bytes enter at the top so byte 0 ends up in bits [7:0]
                    shbuf_n = {bus.in_data, shbuf[BUF_W-1:8]};
                    bidx_n  = 2'(bidx + 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_n   = 8'(sum + bus.in_data);
`endif
                    if (bidx == 2'd3) begin
                        we_n    = 1'b1;
                        waddr_n = wcnt[ADDR_W-1:0];
                        wdata_n = {bus.in_data, shbuf};
                        wcnt_n  = wcnt_inc;
                        if (wcnt_inc == len) begin
                            state_n = S_END;
                        end
                    end
                end
            end
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) begin
                    state_n = (8'(sum + bus.in_data) == 8'd0) ? S_DONE : S_ERR;
                end
`else
                state_n = S_IDLE;
`endif
            end
            default: state_n = S_IDLE;
        endcase

        // Status outputs are registered copies of the state being entered
        in_ready_n = (state_n == S_LEN0) || (state_n == S_LEN1) ||
                     (state_n == S_DATA) || (state_n == S_CSUM);
        busy_n     = in_ready_n;
        done_n     = (state_n == S_DONE);
        err_n      = (state_n == S_ERR);
    end

    assign bus.in_ready = in_ready_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign busy         = busy_q;
    assign core_hold    = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected writes are derived directly
// from the word list of each frame; expected status from the frame rules.
// Build with +define+IMEM_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_imem_loader;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned ADDR_W = 9;

    logic clk;
    logic rst_n;
    logic start;
    logic busy, core_hold, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    int n_cmp;
    int n_err;
    int cyc;

    logic [ADDR_W-1:0] wq_addr[$];
    logic [31:0]       wq_data[$];
    int                wq_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.we === 1'b1) begin
            wq_addr.push_back(bus.waddr);
            wq_data.push_back(bus.wdata);
            wq_cyc.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_writes();
        wq_addr = {};
        wq_data = {};
        wq_cyc  = {};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.in_ready, bus.we, busy, core_hold, done, err} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 000000", {bus.in_ready, bus.we, busy, core_hold, done, err});
        end
        n_cmp++; if (bus.waddr !== '0 || bus.wdata !== 32'h0) begin
            n_err++; $display("FAIL reset_bus: got waddr=%0h wdata=%0h want 0/0", bus.waddr, bus.wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.in_ready, busy, done, err} !== 4'b0) begin
            n_err++; $display("FAIL idle_after_reset: got %b want 0000", {bus.in_ready, busy, done, err});
        end
    endtask

    // Sends one frame built from words; mode 0 back-to-back, 1 every other
    // cycle, 2 random gaps with stray start pulses mid-frame.
    task automatic run_frame(input string name, input logic [31:0] words[$],
                             input int mode, input logic bad_csum);
        logic [7:0] bytes[$];
        logic [7:0] s;
        logic       exp_ok;
        int         len;
        int         gap;
        int         guard;
        len = words.size();
        bytes = {};
        bytes.push_back(8'(len));
        bytes.push_back(8'(len >> 8));
        s = 8'd0;
        for (int k = 0; k < len; k++) begin
            for (int j = 0; j < 4; j++) begin
                bytes.push_back(words[k][8*j +: 8]);
                s = 8'(s + words[k][8*j +: 8]);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        bytes.push_back(bad_csum ? 8'(8'd1 - s) : 8'(8'd0 - s));
        exp_ok = !bad_csum;
`else
        exp_ok = 1'b1;
`endif
        clear_writes();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({busy, core_hold, bus.in_ready, done, err} !== 5'b11100) begin
            n_err++; $display("FAIL %s start_resp: got busy/hold/rdy/done/err=%b want 11100", name, {busy, core_hold, bus.in_ready, done, err});
        end
        for (int i = 0; i < bytes.size(); i++) begin
            gap = (mode == 1 && i > 0) ? 1 : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
            repeat (gap) begin
                bus.in_valid = 1'b0;
                start = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = bytes[i];
            start = (mode == 2) && ($urandom_range(0, 3) == 0);
            guard = 0;
            while (bus.in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                n_cmp++; n_err++;
                $display("FAIL %s stall: in_ready stayed %b at byte %0d want 1", name, bus.in_ready, i);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        n_cmp++; if ({done, err, busy} !== {exp_ok, !exp_ok, 1'b0}) begin
            n_err++; $display("FAIL %s end_status: got done/err/busy=%b want %b (csum_fault=%0b)", name, {done, err, busy}, {exp_ok, !exp_ok, 1'b0}, bad_csum);
        end
`else
        n_cmp++; if ({bus.we, done, busy} !== {(len > 0), exp_ok, 1'b0}) begin
            n_err++; $display("FAIL %s end_status: got we/done/busy=%b want %b (csum_fault=%0b)", name, {bus.we, done, busy}, {(len > 0), exp_ok, 1'b0}, bad_csum);
        end
`endif
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.in_ready, core_hold, done, err} !== {2'b00, exp_ok, !exp_ok}) begin
            n_err++; $display("FAIL %s settled: got rdy/hold/done/err=%b want %b", name, {bus.in_ready, core_hold, done, err}, {2'b00, exp_ok, !exp_ok});
        end
        n_cmp++; if (wq_addr.size() != len) begin
            n_err++; $display("FAIL %s write_count: got %0d want %0d", name, wq_addr.size(), len);
        end else begin
            for (int k = 0; k < len; k++) begin
                n_cmp++; if (wq_addr[k] !== ADDR_W'(k) || wq_data[k] !== words[k]) begin
                    n_err++; $display("FAIL %s write[%0d]: got %0h:%08h want %0h:%08h", name, k, wq_addr[k], wq_data[k], ADDR_W'(k), words[k]);
                end
            end
            if (mode == 1 && len >= 2) begin
                n_cmp++; if (wq_cyc[1] - wq_cyc[0] != 8) begin
                    n_err++; $display("FAIL %s we_spacing: got %0d want 8", name, wq_cyc[1] - wq_cyc[0]);
                end
            end
            if (mode == 0 && len >= 2) begin
                n_cmp++; if (wq_cyc[1] - wq_cyc[0] != 4) begin
                    n_err++; $display("FAIL %s we_spacing: got %0d want 4", name, wq_cyc[1] - wq_cyc[0]);
                end
            end
        end
    endtask

    task automatic test_plan_frame();
        logic [31:0] w[$];
        w = {32'hf9c00393, 32'hff63a313};
        run_frame("b2b", w, 0, 1'b0);
        run_frame("toggle", w, 1, 1'b0);
    endtask

    task automatic test_len0();
        logic [31:0] w[$];
        w = {};
        run_frame("len0", w, 0, 1'b0);
    endtask

    task automatic test_oversize();
        clear_writes();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        @(negedge clk);
        bus.in_data  = 8'h02;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if ({err, done, busy, bus.in_ready} !== 4'b1000) begin
            n_err++; $display("FAIL oversize_status: got err/done/busy/rdy=%b want 1000", {err, done, busy, bus.in_ready});
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (wq_addr.size() != 0) begin
            n_err++; $display("FAIL oversize_writes: got %0d want 0", wq_addr.size());
        end
    endtask

    task automatic test_checksum();
        logic [31:0] w[$];
        w = {32'h00000001};
        run_frame("csum_good", w, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_frame("csum_bad", w, 0, 1'b1);
`endif
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  b[$];
        logic [31:0] w[$];
        b = {8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        clear_writes();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (b[i]) begin
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.in_ready, bus.we, busy, core_hold, done, err} !== 6'b0) begin
            n_err++; $display("FAIL midreset_flags: got %b want 000000", {bus.in_ready, bus.we, busy, core_hold, done, err});
        end
        n_cmp++; if (bus.waddr !== '0 || bus.wdata !== 32'h0) begin
            n_err++; $display("FAIL midreset_bus: got %0h/%0h want 0/0", bus.waddr, bus.wdata);
        end
        n_cmp++; if (wq_addr.size() != 1 || wq_data[0] !== 32'h44332211) begin
            n_err++; $display("FAIL midreset_partial: got %0d writes want 1 of 44332211", wq_addr.size());
        end
        @(negedge clk);
        rst_n = 1'b1;
        w = {$urandom, $urandom, $urandom};
        run_frame("after_reset", w, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        int len;
        for (int f = 0; f < 8; f++) begin
            len = int'($urandom_range(1, 6));
            w = {};
            for (int k = 0; k < len; k++) w.push_back($urandom);
            run_frame("random", w, 2, 1'b0);
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] w[$];
        w = {};
        for (int k = 0; k < int'(DEPTH); k++) w.push_back($urandom);
        run_frame("full_depth", w, 0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        test_reset();
        test_plan_frame();
        test_len0();
        test_oversize();
        test_checksum();
        test_reset_midframe();
        test_random();
        test_full_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory in the Frankenstein single-cycle core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written through a single-cycle write strobe into the instruction memory's write port, and the core is held in reset while a load is in progress. The instruction memory remains the reader, fetching `RAM[pc[31:2]]`; this block is the matching writer.

## Interface
Parameters:
- `DEPTH`, 512 — instruction memory size in 32-bit words.
- `ADDR_W`, 9 — word-address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle pulse that begins a load; ignored while `busy`.
- `in_valid` in 1 — source byte valid.
- `in_data` in 8 — source byte.
- `in_ready` out 1 — loader accepts a byte; a byte transfers when `in_valid && in_ready`.
- `we` out 1 — instruction memory write strobe, one cycle per word.
- `waddr` out ADDR_W — word address for the write.
- `wdata` out 32 — instruction word for the write.
- `busy` out 1 — a load is in progress.
- `core_hold` out 1 — core reset request; equals `busy`.
- `done` out 1 — last load completed successfully; level signal.
- `err` out 1 — last load failed; level signal.

## Operation
Frame format:
- Byte 0 is LEN[7:0] and byte 1 is LEN[15:8], where LEN is the word count.
- These are followed by LEN×4 payload bytes, little-endian per word: the first byte goes to `wdata[7:0]`.
- With `IMEM_LOADER_CHECKSUM_EN` defined, one checksum byte follows the payload.

States and transitions:
- IDLE: on `start`, go to LEN0.
- LEN0: on handshake, go to LEN1.
- LEN1: on handshake, evaluate LEN:
  - LEN > DEPTH → ERR.
  - LEN == 0 → DONE (or CSUM when the macro is defined).
  - otherwise → DATA.
- DATA: loops until word LEN-1 is written, then goes to DONE or CSUM.
- CSUM: on handshake, go to DONE or ERR depending on the checksum result.
- DONE and ERR: on `start`, go to LEN0.

Handshake and datapath:
- `in_ready` is 1 in LEN0, LEN1, DATA and CSUM, and 0 in all other states. Backpressure is never applied mid-frame.
- A 2-bit byte index and a 24-bit shift buffer assemble each word.
- On the 4th byte of a word, the next cycle presents:
  - `we` = 1;
  - `waddr` = word index k, where word k starts at 0 and increments per word;
  - `wdata` = assembled word.
- A byte may be accepted in the same cycle `we` is high; the write path is fully registered, so there is no stall.
- The word counter is 16 bits and is compared against LEN; `waddr` is its low ADDR_W bits.

Status flags:
- `start` clears `done` and `err` on entry to LEN0.
- `done` and `err` are never both 1.
- `start` is ignored while `busy`.
- A mid-operation `rst_n` assertion returns the block to IDLE immediately. Words already written remain in memory, and `done` stays 0.

## Timing
- Reset values: `in_ready`, `we`, `busy`, `core_hold`, `done` and `err` are 0; `waddr` and `wdata` are 0; the state is IDLE.
- `start` sampled at edge T gives `busy` = 1 and `in_ready` = 1 in the cycle after T.
- Write latency is one cycle: `we` pulses the cycle after the 4th-byte handshake.
- `we` is high for exactly 1 cycle per word.
- `waddr` and `wdata` hold their last values when `we` is 0.
- Without the macro, `done` = 1 and `busy` = 0 in the same cycle as the final `we` pulse.
- With the macro, `done` or `err` is asserted the cycle after the checksum handshake.
- ERR on oversize LEN is entered the cycle after the LEN1 handshake, with no writes issued.
- Maximum throughput is 1 byte per cycle, giving 4 cycles per word.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum of the payload bytes is kept, modulo 256; the length bytes are excluded.
  - A CSUM state is added. The frame is valid when (sum + checksum byte) mod 256 == 0.
  - On mismatch, `err` = 1. Words already written are not rolled back.
- `IMEM_LOADER_CHECKSUM_EN` not defined: there is no CSUM state and no sum register; the frame ends after the last payload byte.

## Test plan
- LEN = 2 with bytes 93 03 c0 f9 13 a3 63 ff streamed back-to-back → `we` pulses at `waddr` 0 with `wdata` 0xf9c00393, then at `waddr` 1 with 0xff63a313. `done` = 1 and `busy` = 0 (or after the checksum byte when the macro is defined).
- The same frame with `in_valid` toggled every other cycle → identical writes, with `we` pulses spaced 8 cycles apart.
- LEN = 513 (bytes 01 02) → `err` = 1 the cycle after byte 1, zero `we` pulses, `in_ready` = 0.
- LEN = 0 → `done` without any `we` (the macro build requires checksum byte 00).
- Macro build, LEN = 1, word 0x00000001, checksum FF → `done`. The same frame with checksum 00 → `err` = 1, with the write at `waddr` 0 still performed.
- `rst_n` asserted after the 6th byte of a LEN = 3 frame → all outputs return to 0 asynchronously. A subsequent `start` and a full frame load correctly from `waddr` 0.
